rename_stage: RTL and testbench

Parametrised register-rename stage between the micro-op fetch/decode front end and the ROB/reservation stations. Each cycle it accepts a group of up to WIDTH micro-ops and maps their architectural sources and destinations to physical registers. It allocates destinations from a free-list bitmap and tracks per-physical-register ready bits from completion wakeups. On flush it restores the speculative map from an internally kept committed map, so recovery needs no external replay.

---
 rtl/rename_pkg.sv | 37 +++
 rtl/rename_stage_if.sv | 51 +++++
 rtl/free_list_picker.sv | 30 +++
 rtl/rename_stage.sv | 160 ++++++++++++++++
 tb/tb_rename_stage.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rename_pkg.sv
// Shared configuration, widths and the per-slot output packing for the rename stage.
// Pure definitions; no logic.
package rename_pkg;
  localparam int WIDTH      = 4;
  localparam int ARCH_REGS  = 8;
  localparam int PHYS_REGS  = 32;
  localparam int WAKE_PORTS = 6;
  localparam int CMT_PORTS  = 4;

  localparam int AR_W  = $clog2(ARCH_REGS);
  localparam int PR_W  = $clog2(PHYS_REGS);
  localparam int OP_W  = 4;
  localparam int ROB_W = 5;

  localparam logic [PHYS_REGS-1:0] FREE_RST =
    {{(PHYS_REGS - ARCH_REGS){1'b1}}, {ARCH_REGS{1'b0}}};

  typedef logic [AR_W-1:0] areg_t;
  typedef logic [PR_W-1:0] preg_t;

  typedef enum logic {
    ST_RUN,
    ST_RECOVER
  } state_t;

  typedef struct packed {
    logic             mask;
    logic [OP_W-1:0]  op;
    logic [ROB_W-1:0] rob;
    preg_t            pdst;
    preg_t            pold;
    preg_t            psrc0;
    preg_t            psrc1;
    logic             rdy0;
    logic             rdy1;
  } slot_t;
endpackage

// File: rtl/rename_stage_if.sv
// Front-end group, wakeup, commit, flush and renamed-group signals of the rename stage.
// master = front end / ROB side, slave = rename stage.
interface rename_stage_if;
  import rename_pkg::*;

  logic                     in_valid;
  logic                     in_ready;
  logic [WIDTH-1:0]         in_mask;
  logic [OP_W*WIDTH-1:0]    in_op;
  logic [WIDTH-1:0]         in_dst_en;
  logic [AR_W*WIDTH-1:0]    in_dst;
  logic [AR_W*WIDTH-1:0]    in_src0;
  logic [AR_W*WIDTH-1:0]    in_src1;
  logic [ROB_W*WIDTH-1:0]   in_rob;

  logic [WAKE_PORTS-1:0]      wk_valid;
  logic [PR_W*WAKE_PORTS-1:0] wk_preg;

  logic [CMT_PORTS-1:0]       cmt_valid;
  logic [AR_W*CMT_PORTS-1:0]  cmt_arch;
  logic [PR_W*CMT_PORTS-1:0]  cmt_preg;
  logic [PR_W*CMT_PORTS-1:0]  cmt_old;

  logic                     flush;

  logic                     out_valid;
  logic                     out_ready;
  logic [WIDTH-1:0]         out_mask;
  logic [OP_W*WIDTH-1:0]    out_op;
  logic [ROB_W*WIDTH-1:0]   out_rob;
  logic [PR_W*WIDTH-1:0]    out_pdst;
  logic [PR_W*WIDTH-1:0]    out_pold;
  logic [PR_W*WIDTH-1:0]    out_psrc0;
  logic [PR_W*WIDTH-1:0]    out_psrc1;
  logic [WIDTH-1:0]         out_rdy0;
  logic [WIDTH-1:0]         out_rdy1;

  modport master (
    output in_valid, in_mask, in_op, in_dst_en, in_dst, in_src0, in_src1, in_rob,
    output wk_valid, wk_preg, cmt_valid, cmt_arch, cmt_preg, cmt_old, flush, out_ready,
    input  in_ready, out_valid, out_mask, out_op, out_rob, out_pdst, out_pold,
    input  out_psrc0, out_psrc1, out_rdy0, out_rdy1
  );

  modport slave (
    input  in_valid, in_mask, in_op, in_dst_en, in_dst, in_src0, in_src1, in_rob,
    input  wk_valid, wk_preg, cmt_valid, cmt_arch, cmt_preg, cmt_old, flush, out_ready,
    output in_ready, out_valid, out_mask, out_op, out_rob, out_pdst, out_pold,
    output out_psrc0, out_psrc1, out_rdy0, out_rdy1
  );
endinterface

// File: rtl/free_list_picker.sv
// Returns the K lowest set bits of a bitmap and whether at least K bits are set.
// Combinational, no handshake.
module free_list_picker
  import rename_pkg::*;
#(
  parameter int N = PHYS_REGS,
  parameter int K = WIDTH
) (
  input  logic [N-1:0]         bits,
  output logic [$clog2(N)-1:0] pick [K],
  output logic                 enough
);
  localparam int IW = $clog2(N);
  localparam int CW = $clog2(N + 1);

  // Running popcount; its final value is the total number of set bits.
  logic [CW-1:0] pop;

  always_comb begin
    pop = '0;
    for (int k = 0; k < K; k++) pick[k] = '0;
    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < K; k++) begin
        if (bits[i] && pop == CW'(k)) pick[k] = IW'(i);
      end
      pop = pop + CW'(bits[i]);
    end
    enough = (pop >= CW'(K));
  end
endmodule

// File: rtl/rename_stage.sv
// Register rename: maps a group of up to WIDTH micro-ops to physical registers, 1-cycle latency.
// Output held until out_valid & out_ready; in_ready drops when output busy, free list short, or recovering.
module rename_stage
  import rename_pkg::*;
(
  input logic           clk,
  input logic           rst,
  rename_stage_if.slave bus
);
  state_t state_q, state_n;

  preg_t spec_rat_q [ARCH_REGS];
  preg_t cmt_rat_q  [ARCH_REGS];
  preg_t cmt_rat_n  [ARCH_REGS];
  preg_t ren_rat    [ARCH_REGS];
  logic [ARCH_REGS-1:0] ren_ovr;

  logic [PHYS_REGS-1:0] free_q, ready_q;
  logic [PHYS_REGS-1:0] wake_vec, cmt_free_vec, cmt_mapped, alloc_vec, alloc_gated;

  slot_t ren_slot [WIDTH];
  slot_t out_q    [WIDTH];
  logic  out_valid_q;

  preg_t pick [WIDTH];
  logic  enough;
  logic  accept;

  free_list_picker #(.N(PHYS_REGS), .K(WIDTH)) u_pick (
    .bits   (free_q),
    .pick   (pick),
    .enough (enough)
  );

  assign bus.in_ready = !rst && (state_q == ST_RUN) && enough &&
                        (!out_valid_q || bus.out_ready) && !bus.flush;
  assign accept       = bus.in_valid && bus.in_ready;
  assign alloc_gated  = accept ? alloc_vec : '0;

  always_comb begin
    state_n = state_q;
    if (bus.flush)                   state_n = ST_RECOVER;
    else if (state_q == ST_RECOVER)  state_n = ST_RUN;
  end

  // Wakeups, and the committed map as it will stand after this cycle's commits.
  always_comb begin
    wake_vec = '0;
    for (int w = 0; w < WAKE_PORTS; w++)
      if (bus.wk_valid[w]) wake_vec[bus.wk_preg[w*PR_W +: PR_W]] = 1'b1;

    cmt_free_vec = '0;
    for (int a = 0; a < ARCH_REGS; a++) cmt_rat_n[a] = cmt_rat_q[a];
    for (int j = 0; j < CMT_PORTS; j++) begin
      if (bus.cmt_valid[j]) begin
        cmt_rat_n[bus.cmt_arch[j*AR_W +: AR_W]] = bus.cmt_preg[j*PR_W +: PR_W];
        cmt_free_vec[bus.cmt_old[j*PR_W +: PR_W]] = 1'b1;
      end
    end

    cmt_mapped = '0;
    for (int a = 0; a < ARCH_REGS; a++) cmt_mapped[cmt_rat_n[a]] = 1'b1;
  end

  // Slots walk in order over a working copy of the map so later slots see earlier
  // destinations. Slot k always draws the k-th free register, independent of other slots.
  always_comb begin : rename_comb
    areg_t s0, s1, d;
    for (int a = 0; a < ARCH_REGS; a++) ren_rat[a] = spec_rat_q[a];
    ren_ovr   = '0;
    alloc_vec = '0;
    for (int k = 0; k < WIDTH; k++) begin
      s0 = bus.in_src0[k*AR_W +: AR_W];
      s1 = bus.in_src1[k*AR_W +: AR_W];
      d  = bus.in_dst[k*AR_W +: AR_W];
      ren_slot[k]      = '0;
      ren_slot[k].mask = bus.in_mask[k];
      ren_slot[k].op   = bus.in_op[k*OP_W +: OP_W];
      ren_slot[k].rob  = bus.in_rob[k*ROB_W +: ROB_W];
      if (bus.in_mask[k]) begin
        ren_slot[k].psrc0 = ren_rat[s0];
        ren_slot[k].psrc1 = ren_rat[s1];
        ren_slot[k].rdy0  = !ren_ovr[s0] && (ready_q[ren_rat[s0]] || wake_vec[ren_rat[s0]]);
        ren_slot[k].rdy1  = !ren_ovr[s1] && (ready_q[ren_rat[s1]] || wake_vec[ren_rat[s1]]);
        if (bus.in_dst_en[k]) begin
          ren_slot[k].pdst = pick[k];
          ren_slot[k].pold = ren_rat[d];
          ren_rat[d]       = pick[k];
          ren_ovr[d]       = 1'b1;
          alloc_vec[pick[k]] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_RECOVER;
    else     state_q <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int a = 0; a < ARCH_REGS; a++) begin
        spec_rat_q[a] <= PR_W'(a);
        cmt_rat_q[a]  <= PR_W'(a);
      end
      free_q      <= FREE_RST;
      ready_q     <= '1;
      out_valid_q <= 1'b0;
      for (int k = 0; k < WIDTH; k++) out_q[k] <= '0;
    end else begin
      for (int a = 0; a < ARCH_REGS; a++) cmt_rat_q[a] <= cmt_rat_n[a];

      // Recovery rebuilds speculative state purely from the committed map.
      if (state_q == ST_RECOVER && !bus.flush) begin
        for (int a = 0; a < ARCH_REGS; a++) spec_rat_q[a] <= cmt_rat_n[a];
        free_q  <= ~cmt_mapped;
        ready_q <= ready_q | wake_vec | cmt_mapped;
      end else begin
        free_q  <= (free_q & ~alloc_gated) | cmt_free_vec;
        ready_q <= (ready_q & ~alloc_gated) | wake_vec;
        if (accept)
          for (int a = 0; a < ARCH_REGS; a++) spec_rat_q[a] <= ren_rat[a];
      end

      if (bus.flush) begin
        out_valid_q <= 1'b0;
      end else if (accept) begin
        out_valid_q <= 1'b1;
        for (int k = 0; k < WIDTH; k++) out_q[k] <= ren_slot[k];
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  always_comb begin
    bus.out_valid = out_valid_q;
    bus.out_mask  = '0;
    bus.out_op    = '0;
    bus.out_rob   = '0;
    bus.out_pdst  = '0;
    bus.out_pold  = '0;
    bus.out_psrc0 = '0;
    bus.out_psrc1 = '0;
    bus.out_rdy0  = '0;
    bus.out_rdy1  = '0;
    for (int k = 0; k < WIDTH; k++) begin
      bus.out_mask[k]                  = out_q[k].mask;
      bus.out_op[k*OP_W +: OP_W]       = out_q[k].op;
      bus.out_rob[k*ROB_W +: ROB_W]    = out_q[k].rob;
      bus.out_pdst[k*PR_W +: PR_W]     = out_q[k].pdst;
      bus.out_pold[k*PR_W +: PR_W]     = out_q[k].pold;
      bus.out_psrc0[k*PR_W +: PR_W]    = out_q[k].psrc0;
      bus.out_psrc1[k*PR_W +: PR_W]    = out_q[k].psrc1;
      bus.out_rdy0[k]                  = out_q[k].rdy0;
      bus.out_rdy1[k]                  = out_q[k].rdy1;
    end
  end
endmodule

// File: tb/tb_rename_stage.sv
// Directed bench for rename_stage with hand-computed expected mappings.
module tb_rename_stage;
  import rename_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rename_stage_if bus ();
  rename_stage dut (.clk(clk), .rst(rst), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_grp();
    bus.in_valid  = 1'b0;
    bus.in_mask   = '0;
    bus.in_op     = '0;
    bus.in_dst_en = '0;
    bus.in_dst    = '0;
    bus.in_src0   = '0;
    bus.in_src1   = '0;
    bus.in_rob    = '0;
  endtask

  task automatic clr_side();
    bus.wk_valid  = '0;
    bus.wk_preg   = '0;
    bus.cmt_valid = '0;
    bus.cmt_arch  = '0;
    bus.cmt_preg  = '0;
    bus.cmt_old   = '0;
    bus.flush     = 1'b0;
  endtask

  task automatic slot(input int k, input logic den, input int d, input int s0, input int s1,
                      input int rob);
    bus.in_mask[k]                = 1'b1;
    bus.in_dst_en[k]              = den;
    bus.in_dst[k*AR_W +: AR_W]    = AR_W'(d);
    bus.in_src0[k*AR_W +: AR_W]   = AR_W'(s0);
    bus.in_src1[k*AR_W +: AR_W]   = AR_W'(s1);
    bus.in_op[k*OP_W +: OP_W]     = OP_W'(k + 1);
    bus.in_rob[k*ROB_W +: ROB_W]  = ROB_W'(rob);
  endtask

  function automatic int pdst(input int k);  return int'(bus.out_pdst[k*PR_W +: PR_W]);  endfunction
  function automatic int pold(input int k);  return int'(bus.out_pold[k*PR_W +: PR_W]);  endfunction
  function automatic int psrc0(input int k); return int'(bus.out_psrc0[k*PR_W +: PR_W]); endfunction
  function automatic int psrc1(input int k); return int'(bus.out_psrc1[k*PR_W +: PR_W]); endfunction
  function automatic int rob(input int k);   return int'(bus.out_rob[k*ROB_W +: ROB_W]); endfunction
  function automatic int free_cnt();         return int'(dut.u_pick.pop);                endfunction

  int dst_tbl [4] = '{5, 6, 7, 0};

  initial begin
    rst = 1'b1;
    bus.out_ready = 1'b1;
    clr_grp();
    clr_side();
    tick();
    tick();
    check("rst_in_ready", 32'(bus.in_ready), 0);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_out_pdst", int'(bus.out_pdst), 0);
    check("rst_free_cnt", free_cnt(), 24);
    rst = 1'b0;
    #1;
    check("rel_recover_rdy", 32'(bus.in_ready), 0);
    tick();
    check("rel_run_rdy", 32'(bus.in_ready), 1);

    // Full group writing r1..r4 from the reset free list.
    for (int k = 0; k < 4; k++) slot(k, 1'b1, k + 1, 0, 0, k);
    bus.in_valid = 1'b1;
    #1;
    check("t1_in_ready", 32'(bus.in_ready), 1);
    tick();
    clr_grp();
    check("t1_out_valid", 32'(bus.out_valid), 1);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t1_pdst%0d", k), pdst(k), 8 + k);
      check($sformatf("t1_pold%0d", k), pold(k), k + 1);
      check($sformatf("t1_psrc0_%0d", k), psrc0(k), 0);
      check($sformatf("t1_rdy0_%0d", k), 32'(bus.out_rdy0[k]), 1);
    end

    // Intra-group bypass: slot1 reads r1 just written by slot0.
    slot(0, 1'b1, 1, 0, 0, 5);
    slot(1, 1'b0, 0, 1, 2, 6);
    bus.in_valid = 1'b1;
    tick();
    clr_grp();
    check("t2_pdst0", pdst(0), 12);
    check("t2_pold0", pold(0), 8);
    check("t2_byp_psrc0", psrc0(1), 12);
    check("t2_byp_rdy0", 32'(bus.out_rdy0[1]), 0);
    check("t2_psrc1", psrc1(1), 9);
    check("t2_rdy1", 32'(bus.out_rdy1[1]), 0);
    check("t2_nodst_pdst", pdst(1), 0);
    check("t2_mask", int'(bus.out_mask), 3);

    // Same-cycle wakeup bypass on ports 0 and 5.
    bus.wk_valid = 6'b100001;
    bus.wk_preg[0 +: PR_W]  = 5'd12;
    bus.wk_preg[25 +: PR_W] = 5'd10;
    slot(0, 1'b0, 0, 1, 2, 7);
    slot(1, 1'b0, 0, 3, 3, 8);
    bus.in_valid = 1'b1;
    tick();
    clr_grp();
    clr_side();
    check("t2w_psrc0", psrc0(0), 12);
    check("t2w_rdy0", 32'(bus.out_rdy0[0]), 1);
    check("t2w_rdy1_unwoken", 32'(bus.out_rdy1[0]), 0);
    check("t2w_port5_rdy", 32'(bus.out_rdy0[1]), 1);

    // The wakeup left the ready bit set for later readers.
    slot(0, 1'b0, 0, 1, 4, 9);
    bus.in_valid = 1'b1;
    tick();
    clr_grp();
    check("t2r_rdy0", 32'(bus.out_rdy0[0]), 1);
    check("t2r_psrc1", psrc1(0), 11);
    check("t2r_rdy1", 32'(bus.out_rdy1[0]), 0);

    // Stall: second group held off while out_ready is low.
    slot(0, 1'b1, 6, 0, 0, 21);
    bus.in_valid = 1'b1;
    tick();
    clr_grp();
    bus.out_ready = 1'b0;
    slot(0, 1'b1, 7, 0, 0, 22);
    bus.in_valid = 1'b1;
    #1;
    check("t4_stall_rdy", 32'(bus.in_ready), 0);
    tick();
    check("t4_hold_valid", 32'(bus.out_valid), 1);
    check("t4_hold_pdst", pdst(0), 13);
    tick();
    check("t4_hold_pdst2", pdst(0), 13);
    check("t4_hold_rob", rob(0), 21);
    bus.out_ready = 1'b1;
    #1;
    check("t4_release_rdy", 32'(bus.in_ready), 1);
    tick();
    clr_grp();
    check("t4_second_rob", rob(0), 22);
    check("t4_second_pdst", pdst(0), 14);
    check("t4_second_pold", pold(0), 7);
    tick();
    check("t4_drained", 32'(bus.out_valid), 0);
    check("t4_free_cnt", free_cnt(), 17);

    // Drain the free list to three entries.
    for (int g = 0; g < 4; g++) begin
      for (int k = 0; k < 4; k++)
        if (g < 3 || k < 2) slot(k, 1'b1, dst_tbl[k], 0, 0, g);
      bus.in_valid = 1'b1;
      tick();
      clr_grp();
      check($sformatf("t3_g%0d_pdst0", g), pdst(0), 15 + 4 * g);
    end
    check("t3_pdst1", pdst(1), 28);
    check("t3_pold0", pold(0), 23);
    check("t3_pold1", pold(1), 24);
    check("t3_free_cnt", free_cnt(), 3);
    #1;
    check("t3_starved_rdy", 32'(bus.in_ready), 0);

    // Commit r5 -> 15, freeing phys 5.
    bus.cmt_valid = 4'b0001;
    bus.cmt_arch[0 +: AR_W] = 3'd5;
    bus.cmt_preg[0 +: PR_W] = 5'd15;
    bus.cmt_old[0 +: PR_W]  = 5'd5;
    #1;
    check("t3_cmt_cycle_rdy", 32'(bus.in_ready), 0);
    tick();
    clr_side();
    #1;
    check("t3_freed_rdy", 32'(bus.in_ready), 1);
    slot(0, 1'b1, 1, 0, 0, 3);
    bus.in_valid = 1'b1;
    tick();
    clr_grp();
    check("t3_reuse_pdst", pdst(0), 5);
    check("t3_reuse_pold", pold(0), 12);

    // Plain flush restores everything past the committed map.
    bus.flush = 1'b1;
    #1;
    check("fa_flush_rdy", 32'(bus.in_ready), 0);
    tick();
    bus.flush = 1'b0;
    check("fa_out_valid", 32'(bus.out_valid), 0);
    check("fa_recover_rdy", 32'(bus.in_ready), 0);
    tick();
    check("fa_run_rdy", 32'(bus.in_ready), 1);
    check("fa_free_cnt", free_cnt(), 24);

    // Three groups, commit only the first in the flush cycle.
    slot(0, 1'b1, 1, 0, 0, 1);
    bus.in_valid = 1'b1;
    tick();
    clr_grp();
    check("fb_g1_pdst", pdst(0), 5);
    slot(0, 1'b1, 1, 0, 0, 2);
    bus.in_valid = 1'b1;
    tick();
    clr_grp();
    check("fb_g2_pdst", pdst(0), 8);
    check("fb_g2_pold", pold(0), 5);
    slot(0, 1'b1, 2, 0, 0, 3);
    bus.in_valid = 1'b1;
    tick();
    clr_grp();
    check("fb_g3_pdst", pdst(0), 9);
    bus.flush = 1'b1;
    bus.cmt_valid = 4'b0001;
    bus.cmt_arch[0 +: AR_W] = 3'd1;
    bus.cmt_preg[0 +: PR_W] = 5'd5;
    bus.cmt_old[0 +: PR_W]  = 5'd1;
    slot(0, 1'b1, 3, 1, 2, 4);
    bus.in_valid = 1'b1;
    #1;
    check("fb_flush_rdy", 32'(bus.in_ready), 0);
    tick();
    clr_side();
    check("fb_out_valid", 32'(bus.out_valid), 0);
    check("fb_recover_rdy", 32'(bus.in_ready), 0);
    tick();
    check("fb_out_valid_rec", 32'(bus.out_valid), 0);
    check("fb_run_rdy", 32'(bus.in_ready), 1);
    check("fb_free_cnt", free_cnt(), 24);
    tick();
    clr_grp();
    check("fb_rob", rob(0), 4);
    check("fb_psrc0", psrc0(0), 5);
    check("fb_rdy0", 32'(bus.out_rdy0[0]), 1);
    check("fb_psrc1", psrc1(0), 2);
    check("fb_rdy1", 32'(bus.out_rdy1[0]), 1);
    check("fb_pdst", pdst(0), 1);
    check("fb_pold", pold(0), 3);

    // Reset while a stalled group sits on the output.
    bus.out_ready = 1'b0;
    slot(0, 1'b1, 4, 0, 0, 9);
    bus.in_valid = 1'b1;
    tick();
    clr_grp();
    check("r_stall_valid", 32'(bus.out_valid), 1);
    tick();
    check("r_stall_valid2", 32'(bus.out_valid), 1);
    rst = 1'b1;
    #1;
    check("r_rst_rdy", 32'(bus.in_ready), 0);
    tick();
    check("r_out_valid", 32'(bus.out_valid), 0);
    check("r_out_pdst", int'(bus.out_pdst), 0);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    check("r_recover_rdy", 32'(bus.in_ready), 0);
    tick();
    check("r_run_rdy", 32'(bus.in_ready), 1);
    check("r_free_cnt", free_cnt(), 24);
    for (int k = 0; k < 4; k++) slot(k, 1'b0, 0, k, k + 4, k);
    bus.in_valid = 1'b1;
    tick();
    clr_grp();
    for (int k = 0; k < 4; k++) begin
      check($sformatf("r_id_psrc0_%0d", k), psrc0(k), k);
      check($sformatf("r_id_psrc1_%0d", k), psrc1(k), k + 4);
    end
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
